wave_gen_dds: RTL and testbench
===============================

Name: wave_gen_dds

Overview:
Parametrised direct-digital-synthesis tone generator for the audio path. It advances a phase accumulator on each sample strobe and produces sine, triangle, square or sawtooth samples. Sine uses a mirrored quarter-wave LUT. Output is amplitude-scaled, signed two's-complement, with a one-cycle valid pulse per sample, and feeds the audio mixer/DAC serializer.

Parameters:
PHASE_W, 24, phase accumulator and freq_word width (must be >= OUT_W)
OUT_W, 16, signed output sample width; PEAK = 2^(OUT_W-1)-1
LUT_AW, 6, quarter-wave table address bits; N = 2^LUT_AW, table holds N+1 entries
AMP_W, 8, amplitude control width

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  generator enable; when low, sample_stb is ignored
sample_stb  in  1  one-cycle pulse requesting the next sample; may be high every cycle
freq_word  in  PHASE_W  phase increment per sample, unsigned, modulo 2^PHASE_W
phase_sync  in  1  restarts the accumulator at phase 0
mode  in  2  waveform: 0 sine, 1 triangle, 2 square, 3 saw
amp  in  AMP_W  amplitude; all-ones = unity bypass
music_o  out  OUT_W  signed sample, held between updates
valid_o  out  1  one-cycle pulse when music_o updates

Behaviour:
- Reset (async, rst_n=0): acc=0, all pipeline registers=0, music_o=0, valid_o=0. Deassertion is sampled by clk. A reset mid-pipeline discards in-flight samples.
- Stage 0, on an edge with en & sample_stb:
  - capture ph=acc (pre-increment), mode and amp into the pipeline.
  - acc <= acc + freq_word, wrapping modulo 2^PHASE_W.
  - The first sample after reset uses phase 0.
- phase_sync:
  - phase_sync alone: acc <= 0.
  - phase_sync with an accepted strobe: ph=0 and acc <= freq_word.
  - phase_sync takes priority over the normal increment and is honoured even when en=0.
- en=0: acc holds. Samples already in the pipeline drain normally. music_o holds after the drain.
- Stage 1 (registered waveform), p = ph[PHASE_W-1 -: OUT_W]:
  - sine: quadrant q = ph[PHASE_W-1:PHASE_W-2], k = ph[PHASE_W-3 -: LUT_AW]. T[i] = round(PEAK*sin(pi/2*i/N)) for i = 0..N, built as a constant case table. Q0 gives T[k], Q1 T[N-k], Q2 -T[k], Q3 -T[N-k]. Result is exactly odd-symmetric and never reaches -2^(OUT_W-1).
  - triangle: f = p[OUT_W-1] ? (2^OUT_W-1-p) : p; wave = 2f - PEAK. Range is -PEAK..PEAK, with -PEAK at phase 0.
  - square: p[OUT_W-1]==0 gives +PEAK, else -PEAK.
  - saw: p with its MSB inverted, read as signed; the value -2^(OUT_W-1) is clamped to -PEAK.
- Stage 2 (registered output):
  - amp all-ones: music_o = wave, unscaled.
  - otherwise: music_o = (wave * amp) >>> AMP_W, signed multiply with amp zero-extended, arithmetic shift (floor). amp=0 gives 0.
- Latency: music_o and valid_o update on the 3rd rising edge counting the edge that accepts the strobe. valid_o is high for exactly one cycle per accepted strobe.
- Throughput: one sample per clock. Back-to-back strobes give back-to-back valid_o pulses.
- mode, amp and freq_word changes affect only strobes accepted after the change. In-flight samples keep their captured mode and amp. Phase stays continuous across freq_word and mode changes.

Test Plan:
- Reset, then en=1, mode=0, amp=FF, freq_word=2^18, 64 consecutive strobes (default params): samples 0,8,16,32,48 = 0x0000, 0x5A82, 0x7FFF, 0x0000, 0x8001. Series is odd-symmetric. valid_o follows each strobe by exactly 3 edges.
- mode=2, freq_word=2^22, 4 strobes: 0x7FFF, 0x7FFF, 0x8001, 0x8001. Same stimulus with mode=3: 0x8001, 0xC000, 0x0000, 0x4000. With mode=1: 0x8001, 0x0001, 0x7FFF, 0xFFFF.
- Sine, freq_word=2^18, amp=0x80: peak 0x3FFF and trough 0xC000. amp=0x00: all samples 0x0000 with valid_o still pulsing.
- Wrap and sync: freq_word=2^23+1, 3 strobes: accumulator wraps to 0x000002 with no glitch. Then phase_sync together with a strobe: that sample is 0 and acc=freq_word. phase_sync alone: acc=0.
- Change mode 0->2 one cycle after a strobe: that sample still reflects sine and the next reflects square. Drop en with 2 samples in flight: exactly 2 more valid_o pulses, then music_o holds and acc is frozen.
- Assert rst_n=0 asynchronously between edges mid-stream: music_o=0 and valid_o=0 immediately. No stale valid_o after release. First post-reset sample = 0x0000.

Source files
------------

// File: rtl/wave_gen_dds_if.sv
// rtl/wave_gen_dds_if.sv - control and sample bus of the DDS tone generator
interface wave_gen_dds_if #(
  parameter int PHASE_W = 24,
  parameter int OUT_W   = 16,
  parameter int AMP_W   = 8
);
  logic               en;
  logic               sample_stb;
  logic [PHASE_W-1:0] freq_word;
  logic               phase_sync;
  logic [1:0]         mode;
  logic [AMP_W-1:0]   amp;
  logic [OUT_W-1:0]   music_o;
  logic               valid_o;

  modport master (
    output en, sample_stb, freq_word, phase_sync, mode, amp,
    input  music_o, valid_o
  );

  modport slave (
    input  en, sample_stb, freq_word, phase_sync, mode, amp,
    output music_o, valid_o
  );
endinterface

// File: rtl/wave_gen_dds.sv
// rtl/wave_gen_dds.sv - DDS tone generator: phase accumulator, waveform stage, amplitude stage
module wave_gen_dds #(
  parameter int PHASE_W = 24,
  parameter int OUT_W   = 16,
  parameter int LUT_AW  = 6,
  parameter int AMP_W   = 8
) (
  input logic           clk,
  input logic           rst_n,
  wave_gen_dds_if.slave bus
);
  localparam int N = 1 << LUT_AW;
  localparam logic [OUT_W-1:0]  PEAK     = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]  NEG_PEAK = ~PEAK + 1'b1;
  localparam logic [OUT_W-1:0]  MIN_VAL  = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [LUT_AW:0]   N_IDX    = (LUT_AW+1)'(N);

  // Quarter sine at 65 points, round(32767*sin(pi/2*i/64)).
  function automatic logic [15:0] qtab(input logic [6:0] i);
    case (i)
      7'd0:  qtab = 16'd0;     7'd1:  qtab = 16'd804;   7'd2:  qtab = 16'd1608;
      7'd3:  qtab = 16'd2411;  7'd4:  qtab = 16'd3212;  7'd5:  qtab = 16'd4011;
      7'd6:  qtab = 16'd4808;  7'd7:  qtab = 16'd5602;  7'd8:  qtab = 16'd6393;
      7'd9:  qtab = 16'd7179;  7'd10: qtab = 16'd7962;  7'd11: qtab = 16'd8739;
      7'd12: qtab = 16'd9512;  7'd13: qtab = 16'd10278; 7'd14: qtab = 16'd11039;
      7'd15: qtab = 16'd11793; 7'd16: qtab = 16'd12539; 7'd17: qtab = 16'd13279;
      7'd18: qtab = 16'd14010; 7'd19: qtab = 16'd14732; 7'd20: qtab = 16'd15446;
      7'd21: qtab = 16'd16151; 7'd22: qtab = 16'd16846; 7'd23: qtab = 16'd17530;
      7'd24: qtab = 16'd18204; 7'd25: qtab = 16'd18868; 7'd26: qtab = 16'd19519;
      7'd27: qtab = 16'd20159; 7'd28: qtab = 16'd20787; 7'd29: qtab = 16'd21403;
      7'd30: qtab = 16'd22005; 7'd31: qtab = 16'd22594; 7'd32: qtab = 16'd23170;
      7'd33: qtab = 16'd23731; 7'd34: qtab = 16'd24279; 7'd35: qtab = 16'd24811;
      7'd36: qtab = 16'd25329; 7'd37: qtab = 16'd25832; 7'd38: qtab = 16'd26319;
      7'd39: qtab = 16'd26790; 7'd40: qtab = 16'd27245; 7'd41: qtab = 16'd27683;
      7'd42: qtab = 16'd28105; 7'd43: qtab = 16'd28510; 7'd44: qtab = 16'd28898;
      7'd45: qtab = 16'd29268; 7'd46: qtab = 16'd29621; 7'd47: qtab = 16'd29956;
      7'd48: qtab = 16'd30273; 7'd49: qtab = 16'd30571; 7'd50: qtab = 16'd30852;
      7'd51: qtab = 16'd31113; 7'd52: qtab = 16'd31356; 7'd53: qtab = 16'd31580;
      7'd54: qtab = 16'd31785; 7'd55: qtab = 16'd31971; 7'd56: qtab = 16'd32137;
      7'd57: qtab = 16'd32285; 7'd58: qtab = 16'd32412; 7'd59: qtab = 16'd32521;
      7'd60: qtab = 16'd32609; 7'd61: qtab = 16'd32678; 7'd62: qtab = 16'd32728;
      7'd63: qtab = 16'd32757; 7'd64: qtab = 16'd32767;
      default: qtab = 16'd0;
    endcase
  endfunction

  // The base table is exact at OUT_W=16; other widths rescale it to PEAK with rounding.
  function automatic logic [OUT_W-1:0] sine_mag(input logic [LUT_AW:0] idx);
    logic [6:0]  i64;
    logic [15:0] t;
    i64 = 7'((32'(idx) << 6) >> LUT_AW);
    t   = qtab(i64);
    if (OUT_W == 16) sine_mag = OUT_W'(t);
    else sine_mag = OUT_W'((64'(t) * 64'(PEAK) + 64'd16383) / 64'd32767);
  endfunction

  // Stage 0: accumulator and capture
  logic               accept;
  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] cap_ph;
  logic               s0_vld;
  logic [OUT_W-1:0]   s0_ph;
  logic [1:0]         s0_mode;
  logic [AMP_W-1:0]   s0_amp;

  assign accept = bus.en & bus.sample_stb;
  assign cap_ph = bus.phase_sync ? '0 : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      s0_vld  <= 1'b0;
      s0_ph   <= '0;
      s0_mode <= '0;
      s0_amp  <= '0;
    end else begin
      s0_vld <= accept;
      if (accept) begin
        s0_ph   <= cap_ph[PHASE_W-1 -: OUT_W];
        s0_mode <= bus.mode;
        s0_amp  <= bus.amp;
      end
      if (bus.phase_sync) acc <= accept ? bus.freq_word : '0;
      else if (accept) acc <= acc + bus.freq_word;
    end
  end

  // Stage 1: waveform shaping from the top OUT_W phase bits
  logic [1:0]       quad;
  logic [LUT_AW-1:0] k;
  logic [LUT_AW:0]  idx;
  logic [OUT_W-1:0] mag;
  logic [OUT_W-1:0] flip;
  logic [OUT_W-1:0] saw;
  logic [OUT_W-1:0] wave;

  always_comb begin
    quad = s0_ph[OUT_W-1 -: 2];
    k    = s0_ph[OUT_W-3 -: LUT_AW];
    idx  = quad[0] ? (N_IDX - {1'b0, k}) : {1'b0, k};
    mag  = sine_mag(idx);
    flip = s0_ph[OUT_W-1] ? ~s0_ph : s0_ph;
    saw  = {~s0_ph[OUT_W-1], s0_ph[OUT_W-2:0]};
    case (s0_mode)
      2'd0:    wave = quad[1] ? (~mag + 1'b1) : mag;
      2'd1:    wave = (flip << 1) - PEAK;
      2'd2:    wave = s0_ph[OUT_W-1] ? NEG_PEAK : PEAK;
      default: wave = (saw == MIN_VAL) ? NEG_PEAK : saw;
    endcase
  end

  logic             s1_vld;
  logic [OUT_W-1:0] s1_wave;
  logic [AMP_W-1:0] s1_amp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_wave <= '0;
      s1_amp  <= '0;
    end else begin
      s1_vld <= s0_vld;
      if (s0_vld) begin
        s1_wave <= wave;
        s1_amp  <= s0_amp;
      end
    end
  end

  // Stage 2: amplitude scaling, floor of the arithmetic shift
  logic signed [OUT_W+AMP_W:0] prod;
  assign prod = $signed(s1_wave) * $signed({1'b0, s1_amp});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.music_o <= '0;
      bus.valid_o <= 1'b0;
    end else begin
      bus.valid_o <= s1_vld;
      if (s1_vld) bus.music_o <= (&s1_amp) ? s1_wave : OUT_W'(prod >>> AMP_W);
    end
  end
endmodule

// File: tb/tb_wave_gen_dds.sv
// tb/tb_wave_gen_dds.sv - directed self-checking bench for wave_gen_dds
module tb_wave_gen_dds;
  localparam int PHASE_W = 24;
  localparam int OUT_W   = 16;
  localparam int LUT_AW  = 6;
  localparam int AMP_W   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wave_gen_dds_if #(.PHASE_W(PHASE_W), .OUT_W(OUT_W), .AMP_W(AMP_W)) bus ();

  wave_gen_dds #(.PHASE_W(PHASE_W), .OUT_W(OUT_W), .LUT_AW(LUT_AW), .AMP_W(AMP_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  logic [15:0] got[$];
  int vcyc[$];
  int scyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.valid_o === 1'b1) begin
      got.push_back(bus.music_o);
      vcyc.push_back(cyc);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    got.delete();
    vcyc.delete();
    scyc.delete();
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.sample_stb = 1'b1;
      scyc.push_back(cyc);
    end
    @(negedge clk);
    bus.sample_stb = 1'b0;
  endtask

  task automatic sync_alone();
    @(negedge clk);
    bus.phase_sync = 1'b1;
    @(negedge clk);
    bus.phase_sync = 1'b0;
  endtask

  task automatic test_reset();
    bus.en = 1'b0; bus.sample_stb = 1'b0; bus.phase_sync = 1'b0;
    bus.mode = 2'd0; bus.amp = 8'hFF; bus.freq_word = '0;
    #12;
    total++; if (bus.music_o !== 16'h0000) $display("FAIL reset_music got=%h exp=0000", bus.music_o); else passed++;
    total++; if (bus.valid_o !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bus.valid_o); else passed++;
    total++; if (dut.acc !== 24'h0) $display("FAIL reset_acc got=%h exp=000000", dut.acc); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_sine();
    int bad_sym;
    int bad_lat;
    bus.en = 1'b1; bus.mode = 2'd0; bus.amp = 8'hFF; bus.freq_word = 24'h040000;
    clear_logs();
    strobes(64);
    idle(5);
    total++; if (got.size() != 64) $display("FAIL sine_count got=%0d exp=64", got.size()); else passed++;
    if (got.size() == 64) begin
      total++; if (got[0]  !== 16'h0000) $display("FAIL sine_s0 got=%h exp=0000", got[0]);  else passed++;
      total++; if (got[8]  !== 16'h5A82) $display("FAIL sine_s8 got=%h exp=5a82", got[8]);  else passed++;
      total++; if (got[16] !== 16'h7FFF) $display("FAIL sine_s16 got=%h exp=7fff", got[16]); else passed++;
      total++; if (got[32] !== 16'h0000) $display("FAIL sine_s32 got=%h exp=0000", got[32]); else passed++;
      total++; if (got[48] !== 16'h8001) $display("FAIL sine_s48 got=%h exp=8001", got[48]); else passed++;
      bad_sym = 0;
      for (int i = 0; i < 32; i++) if (got[i+32] !== 16'(-got[i])) bad_sym++;
      total++; if (bad_sym != 0) $display("FAIL sine_odd_sym got=%0d_bad exp=0_bad", bad_sym); else passed++;
      bad_lat = 0;
      for (int i = 0; i < 64; i++) if (vcyc[i] - scyc[i] != 3) bad_lat++;
      total++; if (bad_lat != 0) $display("FAIL sine_latency got=%0d_bad exp=0_bad", bad_lat); else passed++;
    end
    total++; if (dut.acc !== 24'h0) $display("FAIL sine_acc_wrap got=%h exp=000000", dut.acc); else passed++;
  endtask

  task automatic test_shapes();
    logic [1:0]  modes [3];
    logic [15:0] exp_v [3][4];
    modes = '{2'd2, 2'd3, 2'd1};
    exp_v = '{'{16'h7FFF, 16'h7FFF, 16'h8001, 16'h8001},
              '{16'h8001, 16'hC000, 16'h0000, 16'h4000},
              '{16'h8001, 16'h0001, 16'h7FFF, 16'hFFFF}};
    for (int m = 0; m < 3; m++) begin
      bus.mode = modes[m]; bus.freq_word = 24'h400000; bus.amp = 8'hFF;
      sync_alone();
      clear_logs();
      strobes(4);
      idle(5);
      total++; if (got.size() != 4) $display("FAIL shape_count mode=%0d got=%0d exp=4", modes[m], got.size()); else passed++;
      for (int i = 0; i < 4 && i < got.size(); i++) begin
        total++;
        if (got[i] !== exp_v[m][i]) $display("FAIL shape mode=%0d idx=%0d got=%h exp=%h", modes[m], i, got[i], exp_v[m][i]);
        else passed++;
      end
    end
  endtask

  task automatic test_amp();
    int bad;
    bus.mode = 2'd0; bus.freq_word = 24'h040000; bus.amp = 8'h80;
    sync_alone();
    clear_logs();
    strobes(64);
    idle(5);
    total++; if (got.size() != 64) $display("FAIL amp80_count got=%0d exp=64", got.size()); else passed++;
    if (got.size() == 64) begin
      total++; if (got[16] !== 16'h3FFF) $display("FAIL amp80_peak got=%h exp=3fff", got[16]); else passed++;
      total++; if (got[48] !== 16'hC000) $display("FAIL amp80_trough got=%h exp=c000", got[48]); else passed++;
    end
    bus.amp = 8'h00;
    clear_logs();
    strobes(8);
    idle(5);
    total++; if (got.size() != 8) $display("FAIL amp0_count got=%0d exp=8", got.size()); else passed++;
    bad = 0;
    foreach (got[i]) if (got[i] !== 16'h0000) bad++;
    total++; if (bad != 0) $display("FAIL amp0_zero got=%0d_nonzero exp=0_nonzero", bad); else passed++;
  endtask

  task automatic test_wrap_sync();
    bus.mode = 2'd0; bus.amp = 8'hFF; bus.freq_word = 24'h800001;
    sync_alone();
    clear_logs();
    strobes(2);
    total++; if (dut.acc !== 24'h000002) $display("FAIL wrap_acc got=%h exp=000002", dut.acc); else passed++;
    strobes(1);
    total++; if (dut.acc !== 24'h800003) $display("FAIL wrap_acc3 got=%h exp=800003", dut.acc); else passed++;
    idle(5);
    total++; if (got.size() != 3) $display("FAIL wrap_count got=%0d exp=3", got.size()); else passed++;
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      total++; if (got[i] !== 16'h0000) $display("FAIL wrap_sample idx=%0d got=%h exp=0000", i, got[i]); else passed++;
    end
    bus.mode = 2'd2;
    clear_logs();
    @(negedge clk);
    bus.phase_sync = 1'b1; bus.sample_stb = 1'b1;
    @(negedge clk);
    bus.phase_sync = 1'b0; bus.sample_stb = 1'b0;
    total++; if (dut.acc !== 24'h800001) $display("FAIL sync_stb_acc got=%h exp=800001", dut.acc); else passed++;
    idle(5);
    total++; if (got.size() != 1 || got[0] !== 16'h7FFF) $display("FAIL sync_stb_sample got=%h n=%0d exp=7fff", (got.size() > 0) ? got[0] : 16'hxxxx, got.size()); else passed++;
    sync_alone();
    total++; if (dut.acc !== 24'h0) $display("FAIL sync_alone_acc got=%h exp=000000", dut.acc); else passed++;
  endtask

  task automatic test_mode_change();
    bus.mode = 2'd0; bus.amp = 8'hFF; bus.freq_word = 24'h200000;
    sync_alone();
    clear_logs();
    @(negedge clk); bus.sample_stb = 1'b1;
    @(negedge clk); bus.mode = 2'd2;
    @(negedge clk); bus.sample_stb = 1'b0;
    idle(5);
    total++; if (got.size() != 2) $display("FAIL mode_chg_count got=%0d exp=2", got.size()); else passed++;
    if (got.size() == 2) begin
      total++; if (got[0] !== 16'h0000) $display("FAIL mode_chg_old got=%h exp=0000", got[0]); else passed++;
      total++; if (got[1] !== 16'h7FFF) $display("FAIL mode_chg_new got=%h exp=7fff", got[1]); else passed++;
    end
  endtask

  task automatic test_en_drop();
    bus.mode = 2'd3; bus.amp = 8'hFF; bus.freq_word = 24'h400000;
    sync_alone();
    clear_logs();
    @(negedge clk); bus.en = 1'b1; bus.sample_stb = 1'b1;
    @(negedge clk);
    @(negedge clk); bus.en = 1'b0;
    idle(6);
    total++; if (got.size() != 2) $display("FAIL en_drop_count got=%0d exp=2", got.size()); else passed++;
    if (got.size() == 2) begin
      total++; if (got[0] !== 16'h8001 || got[1] !== 16'hC000) $display("FAIL en_drop_vals got=%h,%h exp=8001,c000", got[0], got[1]); else passed++;
    end
    total++; if (bus.music_o !== 16'hC000) $display("FAIL en_drop_hold got=%h exp=c000", bus.music_o); else passed++;
    total++; if (dut.acc !== 24'h800000) $display("FAIL en_drop_acc got=%h exp=800000", dut.acc); else passed++;
    bus.sample_stb = 1'b0; bus.en = 1'b1;
  endtask

  task automatic test_async_reset();
    bus.mode = 2'd2; bus.amp = 8'hFF; bus.freq_word = 24'h400000;
    sync_alone();
    @(negedge clk); bus.sample_stb = 1'b1;
    idle(4);
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.music_o !== 16'h0000) $display("FAIL arst_music got=%h exp=0000", bus.music_o); else passed++;
    total++; if (bus.valid_o !== 1'b0) $display("FAIL arst_valid got=%b exp=0", bus.valid_o); else passed++;
    bus.sample_stb = 1'b0; bus.mode = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    idle(5);
    total++; if (got.size() != 0) $display("FAIL arst_stale_valid got=%0d exp=0", got.size()); else passed++;
    strobes(1);
    idle(5);
    total++; if (got.size() != 1 || got[0] !== 16'h0000) $display("FAIL arst_first_sample got=%h n=%0d exp=0000", (got.size() > 0) ? got[0] : 16'hxxxx, got.size()); else passed++;
  endtask

  initial begin
    test_reset();
    test_sine();
    test_shapes();
    test_amp();
    test_wrap_sync();
    test_mode_change();
    test_en_drop();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
